// File: rtl/pattern_match_ctrl.sv
// rtl/pattern_match_ctrl.sv - programmable serial pattern detector with start/stop sequencing and hit counter
// Optional feature macro: PM_OVERLAP_EN (overlapping matches when defined)
module pattern_match_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b1101)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] tgt_in,
    input  logic             start,
    input  logic             stop,
    input  logic             w,
    output logic             match,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [PAT_W-1:0]  pattern;
    logic [CNT_W-1:0]  target;
    logic [PAT_W-1:0]  history;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic [CNT_W-1:0]  count_inc;
    logic              hit;

    // Next shift-window contents and hit detection for the bit sampled this edge
    always_comb begin
        hist_next = {history[PAT_W-2:0], w};
        fill_next = (fill == FILL_FULL) ? fill : fill + 1'b1;
        count_inc = (count == '1) ? count : count + 1'b1;
        hit       = (hist_next == pattern) && (fill_next == FILL_FULL);
    end

    // Controller FSM with registered outputs; reset takes priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            match   <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pattern <= DEFAULT_PAT;
            target  <= '0;
            history <= '0;
            fill    <= '0;
        end else begin
            match <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load) begin
                        pattern <= pat_in;
                        target  <= tgt_in;
                    end
                    if (start && !stop) begin
                        state   <= S_ARMED;
                        busy    <= 1'b1;
                        count   <= '0;
                        history <= '0;
                        fill    <= '0;
                    end
                end
                S_ARMED: begin
                    if (stop) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (start) begin
                        count   <= '0;
                        history <= '0;
                        fill    <= '0;
                    end else begin
                        history <= hist_next;
                        fill    <= fill_next;
                        if (hit) begin
                            match <= 1'b1;
                            count <= count_inc;
`ifndef PM_OVERLAP_EN
                            // Non-overlapping: next hit needs a completely fresh window
                            history <= '0;
                            fill    <= '0;
`endif
                            if ((target != '0) && (count_inc == target)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (stop) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state   <= S_ARMED;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        count   <= '0;
                        history <= '0;
                        fill    <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// tb/tb_pattern_match_ctrl.sv - directed plus random checks of pattern_match_ctrl against a queue-based model
module tb_pattern_match_ctrl;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [CNT_W-1:0] tgt_in = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             w = 1'b0;
    logic             match;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 armed, 2 done; q holds bits sampled since last clear
    int   m_mode;
    int   m_count;
    bit   m_match;
    int   m_pat;
    int   m_tgt;
    bit   q[$];

    pattern_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .load(load), .pat_in(pat_in), .tgt_in(tgt_in),
        .start(start), .stop(stop), .w(w),
        .match(match), .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".match"}, int'(match), int'(m_match));
        check({tag, ".count"}, int'(count), m_count);
        check({tag, ".busy"},  int'(busy),  int'(m_mode == 1));
        check({tag, ".done"},  int'(done),  int'(m_mode == 2));
    endtask

    function automatic int window_value();
        int v = 0;
        foreach (q[i]) v = (v << 1) | int'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_match = 0; m_pat = 'b1101; m_tgt = 0;
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; load = 0; start = 0; stop = 0; w = 0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        check_all(tag);
    endtask

    task automatic step(input string tag, input bit l, input int p, input int t,
                        input bit s, input bit sp, input bit wi);
        load = l; pat_in = PAT_W'(p); tgt_in = CNT_W'(t); start = s; stop = sp; w = wi;
        m_match = 0;
        case (m_mode)
            0: begin
                if (l) begin m_pat = p; m_tgt = t; end
                if (s && !sp) begin m_mode = 1; m_count = 0; q.delete(); end
            end
            1: begin
                if (sp) m_mode = 0;
                else if (s) begin m_count = 0; q.delete(); end
                else begin
                    q.push_back(wi);
                    if (q.size() > PAT_W) void'(q.pop_front());
                    if (q.size() == PAT_W && window_value() == m_pat) begin
                        m_match = 1;
                        if (m_count < CNT_MAX) m_count++;
`ifndef PM_OVERLAP_EN
                        q.delete();
`endif
                        if (m_tgt != 0 && m_count == m_tgt) m_mode = 2;
                    end
                end
            end
            default: begin
                if (sp) m_mode = 0;
                else if (s) begin m_mode = 1; m_count = 0; q.delete(); end
            end
        endcase
        @(posedge clk); #1;
        load = 0; start = 0; stop = 0;
        check_all(tag);
    endtask

    task automatic feed(input string tag, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 0, 0, 0, 0, 0, bits[i]);
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        // Basic detection with the default pattern
        step("arm1", 0, 0, 0, 1, 0, 0);
        feed("t1", 32'b1101, 4);
        check("t1_match_const", int'(match), 1);
        check("t1_count_const", int'(count), 1);
        check("t1_busy_const", int'(busy), 1);
        step("t1_after", 0, 0, 0, 0, 0, 0);
        check("t1_pulse_width", int'(match), 0);

        // Overlap behaviour
        step("arm2", 0, 0, 0, 1, 0, 0);
        feed("t2", 32'b1101101, 7);
`ifdef PM_OVERLAP_EN
        check("t2_count_const", int'(count), 2);
`else
        check("t2_count_const", int'(count), 1);
`endif

        // Loaded pattern and target reach DONE
        step("stop3", 0, 0, 0, 0, 1, 0);
        step("load3", 1, 'b0110, 2, 0, 0, 0);
        step("arm3", 0, 0, 0, 1, 0, 0);
        feed("t3", 32'b01100110, 8);
        check("t3_done_const", int'(done), 1);
        check("t3_busy_const", int'(busy), 0);
        check("t3_count_const", int'(count), 2);
        feed("t3_post", 32'b0110, 4);
        check("t3_post_count", int'(count), 2);

        // Stop mid-stream holds count; re-arm clears history
        step("stop4", 0, 0, 0, 0, 1, 0);
        step("load4", 1, 'b1101, 0, 0, 0, 0);
        step("arm4", 0, 0, 0, 1, 0, 0);
        feed("t4a", 32'b1101110, 7);
        step("stop4b", 0, 0, 0, 0, 1, 1);
        check("t4_count_held", int'(count), 1);
        check("t4_idle_busy", int'(busy), 0);
        step("arm4b", 0, 0, 0, 1, 0, 0);
        step("t4_one_bit", 0, 0, 0, 0, 0, 1);
        check("t4_no_partial", int'(match), 0);

        // start+stop together in IDLE stays IDLE
        step("stop5", 0, 0, 0, 0, 1, 0);
        step("both5", 0, 0, 0, 1, 1, 0);
        check("t5_busy_const", int'(busy), 0);

        // load ignored while ARMED
        step("arm6", 0, 0, 0, 1, 0, 0);
        step("load6", 1, 'b0000, 1, 0, 0, 1);
        feed("t6", 32'b101, 3);
        check("t6_pattern_kept", int'(count), 1);

        // reset while ARMED
        feed("t7", 32'b11, 2);
        do_reset("reset_armed");

        // Free-running counter saturates
        step("arm8", 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 20; k++) feed("t8", 32'b1101, 4);
        check("t8_sat_count", int'(count), CNT_MAX);
        check("t8_never_done", int'(done), 0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                step("rnd",
                     $urandom_range(0, 19) == 0,
                     int'($urandom_range(0, (1 << PAT_W) - 1)),
                     int'($urandom_range(0, 3)),
                     $urandom_range(0, 29) == 0,
                     $urandom_range(0, 39) == 0,
                     1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
